cpu_mailbox: RTL and testbench

Memory-mapped byte mailbox that sits as a responder on the CPU's 13-bit address / 8-bit bidirectional data bus, alongside ram and rom, selected by its own enable from addr_decode. CPU writes are pushed into a TX FIFO that an external consumer drains with a valid/ready handshake. Bytes from an external producer land in a single RX holding register that the CPU reads back. This block gives diagnostic programs a way to emit results and receive stimulus without peeking into RAM.

---
 rtl/cpu_mailbox.sv | 138 +++++++++++++
 tb/tb_cpu_mailbox.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mailbox.sv
// CPU byte mailbox: 4-register responder with a TX FIFO to a valid/ready consumer and an RX holding register.
// Latency: bus reads combinational, writes/pops/rx loads take effect at the clk edge; irq adds 1 cycle.
// Backpressure: TX consumer stalls via tx_ready, full pushes drop (TXOVF); RX has none, overruns set RXOVR. Macro: CPU_MAILBOX_IRQ_EN.
module cpu_mailbox #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] addr,
    inout  wire  [7:0] data,
    input  logic       rd,
    input  logic       wr,
    input  logic       ena,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       irq
);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, count;
    logic        wr_arm_q, rd_arm_q;
    logic [7:0]  rx_hold_q, rx_hold_d;
    logic        rxf_q, rxf_d, rxovr_q, rxovr_d, txovf_q, txovf_d;
    logic [1:0]  ctrl_q, ctrl_d;

    logic        wr_sel, rd_sel, wr_ev, rd_ev;
    logic        push_req, push, pop, full, empty;
    logic        data_rd_ev, status_wr, ctrl_wr;
    logic        irq_bit;
    logic [7:0]  rdata;

    // The arm registers only go high after the strobe has been seen low, so a
    // strobe held through reset release never fires.
    assign wr_sel = ena & wr;
    assign rd_sel = ena & rd & ~wr;
    assign wr_ev  = wr_sel & wr_arm_q;
    assign rd_ev  = rd_sel & rd_arm_q;

    assign count    = wptr_q - rptr_q;
    assign empty    = (wptr_q == rptr_q);
    assign full     = (count == (AW+1)'(DEPTH));
    assign tx_valid = ~empty;
    assign tx_data  = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];

    assign pop        = tx_valid & tx_ready;
    assign push_req   = wr_ev & (addr == 2'd0);
    assign push       = push_req & (~full | pop);
    assign data_rd_ev = rd_ev & (addr == 2'd0);
    assign status_wr  = wr_ev & (addr == 2'd1);
    assign ctrl_wr    = wr_ev & (addr == 2'd3);

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        rx_hold_d = rx_hold_q;
        rxf_d     = rxf_q;
        rxovr_d   = rxovr_q;
        txovf_d   = txovf_q;
        ctrl_d    = ctrl_q;

        if (push) wptr_d = wptr_q + (AW+1)'(1);
        if (pop)  rptr_d = rptr_q + (AW+1)'(1);

        // Clears apply first so a same-cycle overflow event still sticks.
        if (status_wr && data[3]) rxovr_d = 1'b0;
        if (status_wr && data[4]) txovf_d = 1'b0;
        if (push_req && full && !pop) txovf_d = 1'b1;

        if (rx_valid) begin
            rx_hold_d = rx_data;
            rxf_d     = 1'b1;
            if (rxf_q && !data_rd_ev) rxovr_d = 1'b1;
        end else if (data_rd_ev) begin
            rxf_d = 1'b0;
        end

        if (ctrl_wr) ctrl_d = data[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            wr_arm_q  <= 1'b0;
            rd_arm_q  <= 1'b0;
            rx_hold_q <= 8'h00;
            rxf_q     <= 1'b0;
            rxovr_q   <= 1'b0;
            txovf_q   <= 1'b0;
            ctrl_q    <= 2'b00;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            wr_arm_q  <= ~wr_sel;
            rd_arm_q  <= ~rd_sel;
            rx_hold_q <= rx_hold_d;
            rxf_q     <= rxf_d;
            rxovr_q   <= rxovr_d;
            txovf_q   <= txovf_d;
            ctrl_q    <= ctrl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= data;
    end

`ifdef CPU_MAILBOX_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= (ctrl_q[0] & rxf_q) | (ctrl_q[1] & empty);
    end
    assign irq     = irq_q;
    assign irq_bit = irq_q;
`else
    assign irq     = 1'b0;
    assign irq_bit = 1'b0;
`endif

    always_comb begin
        rdata = 8'h00;
        case (addr)
            2'd0: rdata = rx_hold_q;
            2'd1: rdata = {2'b00, irq_bit, txovf_q, rxovr_q, rxf_q, full, empty};
            2'd2: rdata = 8'(count);
            2'd3: rdata = {6'b000000, ctrl_q};
            default: rdata = 8'h00;
        endcase
    end

    assign data = rd_sel ? rdata : 8'hzz;

endmodule

// File: tb/tb_cpu_mailbox.sv
// Directed self-checking bench for cpu_mailbox: register map, TX FIFO, RX overrun and irq behaviour.
module tb_cpu_mailbox;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] addr = 2'd0;
    logic       rd = 1'b0, wr = 1'b0, ena = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] cpu_dout = 8'h00;
    logic       cpu_oe = 1'b0;
    wire  [7:0] data;
    logic [7:0] tx_data;
    logic       tx_valid, irq;

    int n_checks = 0;
    int n_fail   = 0;

    assign data = cpu_oe ? cpu_dout : 8'hzz;

    always #5 clk = ~clk;

    cpu_mailbox #(.DEPTH(8), .AW(3)) dut (
        .clk(clk), .reset(reset), .addr(addr), .data(data),
        .rd(rd), .wr(wr), .ena(ena),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
    );

    task automatic cpu_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; cpu_dout = d; cpu_oe = 1'b1; ena = 1'b1; wr = 1'b1;
        repeat (2) @(negedge clk);
        wr = 1'b0; ena = 1'b0; cpu_oe = 1'b0;
        @(negedge clk);
    endtask

    task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; ena = 1'b1; rd = 1'b1;
        #1 d = data;
        @(negedge clk);
        rd = 1'b0; ena = 1'b0;
        @(negedge clk);
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        @(negedge clk);
        rx_data = d; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq); end
        cpu_dout = 8'h00; cpu_oe = 1'b1;
        #1;
        n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL idle_bus_undriven: got %h want 00", data); end
        cpu_oe = 1'b0;
        cpu_read(2'd1, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL rst_status: got %h want 01", v); end
        cpu_read(2'd2, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL rst_count: got %h want 00", v); end
    endtask

    task automatic test_basic_tx;
        logic [7:0] v;
        cpu_write(2'd0, 8'hA5);
        cpu_write(2'd0, 8'h3C);
        cpu_read(2'd2, v);
        n_checks++; if (v !== 8'h02) begin n_fail++; $display("FAIL basic_count2: got %h want 02", v); end
        n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_head: got %h want a5", tx_data); end
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", tx_valid); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        n_checks++; if (tx_data !== 8'h3C) begin n_fail++; $display("FAIL basic_head2: got %h want 3c", tx_data); end
        cpu_read(2'd2, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL basic_count1: got %h want 01", v); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL basic_drained: got valid %b data %h want 0/00", tx_valid, tx_data); end
    endtask

    task automatic test_overflow_and_push_pop;
        logic [7:0] v;
        logic [7:0] exp_b;
        for (int i = 0; i < 8; i++) cpu_write(2'd0, 8'(i + 1));
        cpu_write(2'd0, 8'hFF);
        cpu_read(2'd1, v);
        n_checks++; if (v !== 8'h12) begin n_fail++; $display("FAIL ovf_status: got %h want 12", v); end
        cpu_read(2'd2, v);
        n_checks++; if (v !== 8'h08) begin n_fail++; $display("FAIL ovf_count: got %h want 08", v); end
        n_checks++; if (tx_data !== 8'h01) begin n_fail++; $display("FAIL ovf_head: got %h want 01", tx_data); end
        cpu_write(2'd1, 8'h10);
        cpu_read(2'd1, v);
        n_checks++; if (v !== 8'h02) begin n_fail++; $display("FAIL ovf_w1c: got %h want 02", v); end
        // Push event and pop share the same edge while full.
        @(negedge clk);
        addr = 2'd0; cpu_dout = 8'hEE; cpu_oe = 1'b1; ena = 1'b1; wr = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        @(negedge clk);
        wr = 1'b0; ena = 1'b0; cpu_oe = 1'b0;
        @(negedge clk);
        cpu_read(2'd2, v);
        n_checks++; if (v !== 8'h08) begin n_fail++; $display("FAIL pushpop_count: got %h want 08", v); end
        cpu_read(2'd1, v);
        n_checks++; if (v !== 8'h02) begin n_fail++; $display("FAIL pushpop_status: got %h want 02", v); end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_b = (i < 7) ? 8'(i + 2) : 8'hEE;
            n_checks++; if (tx_data !== exp_b) begin n_fail++; $display("FAIL drain_%0d: got %h want %h", i, tx_data, exp_b); end
            @(negedge clk);
        end
        tx_ready = 1'b0;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", tx_valid); end
    endtask

    task automatic test_rx_overrun;
        logic [7:0] v;
        rx_pulse(8'h5A);
        rx_pulse(8'h77);
        cpu_read(2'd1, v);
        n_checks++; if (v !== 8'h0D) begin n_fail++; $display("FAIL rxovr_status: got %h want 0d", v); end
        cpu_read(2'd0, v);
        n_checks++; if (v !== 8'h77) begin n_fail++; $display("FAIL rxovr_data: got %h want 77", v); end
        cpu_read(2'd1, v);
        n_checks++; if (v !== 8'h09) begin n_fail++; $display("FAIL rx_cleared: got %h want 09", v); end
        cpu_write(2'd1, 8'h08);
        cpu_read(2'd1, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL rxovr_w1c: got %h want 01", v); end
        cpu_read(2'd0, v);
        n_checks++; if (v !== 8'h77) begin n_fail++; $display("FAIL rx_stale: got %h want 77", v); end
        cpu_read(2'd1, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL rx_stale_status: got %h want 01", v); end
    endtask

    task automatic test_rx_collision;
        logic [7:0] v;
        rx_pulse(8'h11);
        @(negedge clk);
        addr = 2'd0; ena = 1'b1; rd = 1'b1; rx_data = 8'h22; rx_valid = 1'b1;
        #1 v = data;
        @(negedge clk);
        rx_valid = 1'b0; rd = 1'b0; ena = 1'b0;
        @(negedge clk);
        n_checks++; if (v !== 8'h11) begin n_fail++; $display("FAIL coll_read: got %h want 11", v); end
        cpu_read(2'd1, v);
        n_checks++; if (v !== 8'h05) begin n_fail++; $display("FAIL coll_status: got %h want 05", v); end
        cpu_read(2'd0, v);
        n_checks++; if (v !== 8'h22) begin n_fail++; $display("FAIL coll_newbyte: got %h want 22", v); end
        cpu_read(2'd1, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL coll_after: got %h want 01", v); end
    endtask

    task automatic test_ctrl;
        logic [7:0] v;
        cpu_write(2'd3, 8'hFF);
        cpu_read(2'd3, v);
        n_checks++; if (v !== 8'h03) begin n_fail++; $display("FAIL ctrl_ff: got %h want 03", v); end
        cpu_write(2'd3, 8'h00);
        cpu_read(2'd3, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL ctrl_00: got %h want 00", v); end
    endtask

    task automatic test_irq;
        logic [7:0] v;
`ifdef CPU_MAILBOX_IRQ_EN
        cpu_write(2'd3, 8'h01);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle: got %b want 0", irq); end
        rx_pulse(8'h42);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_latency: got %b want 0", irq); end
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rx: got %b want 1", irq); end
        cpu_read(2'd1, v);
        n_checks++; if (v !== 8'h25) begin n_fail++; $display("FAIL irq_status: got %h want 25", v); end
        cpu_read(2'd0, v);
        n_checks++; if (v !== 8'h42) begin n_fail++; $display("FAIL irq_data: got %h want 42", v); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_drop: got %b want 0", irq); end
        cpu_write(2'd3, 8'h02);
        n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_txe: got %b want 1", irq); end
        cpu_write(2'd3, 8'h00);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_off: got %b want 0", irq); end
`else
        cpu_write(2'd3, 8'h03);
        rx_pulse(8'h42);
        repeat (2) @(negedge clk);
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_tied: got %b want 0", irq); end
        cpu_read(2'd1, v);
        n_checks++; if (v !== 8'h05) begin n_fail++; $display("FAIL irq_status_bit5: got %h want 05", v); end
        cpu_read(2'd0, v);
        n_checks++; if (v !== 8'h42) begin n_fail++; $display("FAIL irq_data: got %h want 42", v); end
        n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_tied2: got %b want 0", irq); end
        cpu_write(2'd3, 8'h00);
`endif
    endtask

    task automatic test_reset_midflight;
        logic [7:0] v;
        cpu_write(2'd0, 8'hAA);
        cpu_write(2'd0, 8'hBB);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b want 0", tx_valid); end
        @(negedge clk);
        reset = 1'b0;
        cpu_write(2'd0, 8'hCC);
        n_checks++; if (tx_data !== 8'hCC) begin n_fail++; $display("FAIL rst_first_push: got %h want cc", tx_data); end
        cpu_read(2'd2, v);
        n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL rst_push_count: got %h want 01", v); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        // Write strobe held across reset release must not push.
        @(negedge clk);
        addr = 2'd0; cpu_dout = 8'h99; cpu_oe = 1'b1; ena = 1'b1; wr = 1'b1;
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        wr = 1'b0; ena = 1'b0; cpu_oe = 1'b0;
        @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL held_wr_valid: got %b want 0", tx_valid); end
        cpu_read(2'd2, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL held_wr_count: got %h want 00", v); end
    endtask

    initial begin
        test_reset();
        test_basic_tx();
        test_overflow_and_push_pop();
        test_rx_overrun();
        test_rx_collision();
        test_ctrl();
        test_irq();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
